bcd_countdown99: RTL and testbench

//   Two-digit BCD down-counter/timer (99..00), the counting-down counterpart of the team's 00..99 BCD up-counter.

---
 rtl/bcd_pkg.sv | 12 +
 rtl/bcd_countdown99_if.sv | 19 +
 rtl/bcd_prescaler.sv | 23 ++
 rtl/bcd_countdown99.sv | 101 ++++++++++
 tb/tb_bcd_countdown99.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, counter FSM states and digit validity helper.
package bcd_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    function automatic logic bcd_valid(input bcd_t d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_countdown99_if.sv
// bcd_countdown99_if: load/start/enable controls and digit/status outputs of the countdown timer.
interface bcd_countdown99_if;
    import bcd_pkg::*;

    logic LD;
    bcd_t LdH;
    bcd_t LdL;
    logic START;
    logic EN;
    bcd_t CntH;
    bcd_t CntL;
    logic Busy;
    logic Done;
    logic Err;

    modport master (output LD, LdH, LdL, START, EN, input CntH, CntL, Busy, Done, Err);
    modport slave  (input LD, LdH, LdL, START, EN, output CntH, CntL, Busy, Done, Err);

endinterface

// File: rtl/bcd_prescaler.sv
// bcd_prescaler: modulo-DIV cycle counter; tick marks the enabled cycle that wraps it.
module bcd_prescaler #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick  = en && cnt_q == LAST;
    assign cnt_d = clr ? '0 : !en ? cnt_q : tick ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        cnt_q <= rst ? '0 : cnt_d;
    end

endmodule

// File: rtl/bcd_countdown99.sv
// bcd_countdown99: two-digit BCD countdown timer with load validation, pause and optional auto-reload.
module bcd_countdown99
    import bcd_pkg::*;
#(
    parameter int DIV         = 1,
    parameter bit AUTO_RELOAD = 1'b0,
    parameter int PRE_H       = 5,
    parameter int PRE_L       = 9
) (
    input  logic CP,
    input  logic CR,
    bcd_countdown99_if.slave bus
);
    if (DIV < 1 || PRE_H > 9 || PRE_L > 9) begin : g_bad_param
        $error("bcd_countdown99: DIV must be >=1 and preset digits must be 0..9");
    end

    localparam bcd_t PRE_HB = bcd_t'(PRE_H);
    localparam bcd_t PRE_LB = bcd_t'(PRE_L);

    state_e state_q, state_d;
    bcd_t   cnt_h_q, cnt_h_d, cnt_l_q, cnt_l_d;
    bcd_t   rl_h_q, rl_h_d, rl_l_q, rl_l_d;
    logic   done_q, done_d, err_q, err_d;
    logic   tick, ld_ok, start_ok, step, is_zero, is_one, rl_zero;

    assign ld_ok    = bcd_valid(bus.LdH) && bcd_valid(bus.LdL);
    assign is_zero  = cnt_h_q == 4'd0 && cnt_l_q == 4'd0;
    assign is_one   = cnt_h_q == 4'd0 && cnt_l_q == 4'd1;
    assign rl_zero  = rl_h_q == 4'd0 && rl_l_q == 4'd0;
    assign start_ok = !bus.LD && bus.START && state_q == IDLE;
    assign step     = !bus.LD && tick;

    // A load owns its edge, so the prescaler neither advances nor steps under LD.
    bcd_prescaler #(.DIV(DIV)) u_pre (
        .clk  (CP),
        .rst  (CR),
        .clr  ((bus.LD && ld_ok) || start_ok),
        .en   (state_q == RUN && bus.EN && !bus.LD),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        cnt_h_d = cnt_h_q;
        cnt_l_d = cnt_l_q;
        rl_h_d  = rl_h_q;
        rl_l_d  = rl_l_q;
        done_d  = 1'b0;
        err_d   = err_q;
        if (bus.LD) begin
            err_d = !ld_ok;
            if (ld_ok) begin
                {cnt_h_d, cnt_l_d} = {bus.LdH, bus.LdL};
                {rl_h_d, rl_l_d}   = {bus.LdH, bus.LdL};
                state_d            = IDLE;
            end
        end else if (start_ok) begin
            done_d  = is_zero;
            state_d = is_zero ? IDLE : RUN;
        end else if (step && is_one) begin
            done_d = 1'b1;
            if (AUTO_RELOAD && !rl_zero) begin
                {cnt_h_d, cnt_l_d} = {rl_h_q, rl_l_q};
            end else begin
                {cnt_h_d, cnt_l_d} = 8'h00;
                state_d            = IDLE;
            end
        end else if (step) begin
            cnt_l_d = cnt_l_q == 4'd0 ? 4'd9 : cnt_l_q - 4'd1;
            cnt_h_d = cnt_l_q == 4'd0 ? cnt_h_q - 4'd1 : cnt_h_q;
        end
    end

    always_ff @(posedge CP) begin
        if (CR) begin
            state_q <= IDLE;
            cnt_h_q <= PRE_HB;
            cnt_l_q <= PRE_LB;
            rl_h_q  <= PRE_HB;
            rl_l_q  <= PRE_LB;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_h_q <= cnt_h_d;
            cnt_l_q <= cnt_l_d;
            rl_h_q  <= rl_h_d;
            rl_l_q  <= rl_l_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.CntH = cnt_h_q;
    assign bus.CntL = cnt_l_q;
    assign bus.Busy = state_q == RUN;
    assign bus.Done = done_q;
    assign bus.Err  = err_q;

endmodule

// File: tb/tb_bcd_countdown99.sv
// tb_bcd_countdown99: three timer variants driven in lockstep, checked against a decimal reference model.
module tb_bcd_countdown99;

    logic       CP = 1'b0;
    logic       cr = 1'b0, ld = 1'b0, st = 1'b0, en = 1'b0;
    logic [3:0] ldh = 4'd0, ldl = 4'd0;

    always #5 CP = ~CP;

    bcd_countdown99_if b0 ();
    bcd_countdown99_if b1 ();
    bcd_countdown99_if b2 ();

    assign b0.LD = ld; assign b0.LdH = ldh; assign b0.LdL = ldl; assign b0.START = st; assign b0.EN = en;
    assign b1.LD = ld; assign b1.LdH = ldh; assign b1.LdL = ldl; assign b1.START = st; assign b1.EN = en;
    assign b2.LD = ld; assign b2.LdH = ldh; assign b2.LdL = ldl; assign b2.START = st; assign b2.EN = en;

    bcd_countdown99 #(.DIV(1), .AUTO_RELOAD(1'b0)) u0 (.CP(CP), .CR(cr), .bus(b0));
    bcd_countdown99 #(.DIV(4), .AUTO_RELOAD(1'b0)) u1 (.CP(CP), .CR(cr), .bus(b1));
    bcd_countdown99 #(.DIV(3), .AUTO_RELOAD(1'b1)) u2 (.CP(CP), .CR(cr), .bus(b2));

    logic [32:0] obs;
    assign obs = {b0.CntH, b0.CntL, b0.Busy, b0.Done, b0.Err,
                  b1.CntH, b1.CntL, b1.Busy, b1.Done, b1.Err,
                  b2.CntH, b2.CntL, b2.Busy, b2.Done, b2.Err};

    int DIVS [3] = '{1, 4, 3};
    bit ARS  [3] = '{1'b0, 1'b0, 1'b1};
    int m_cnt[3] = '{0, 0, 0};
    int m_rl [3] = '{0, 0, 0};
    int m_ph [3] = '{0, 0, 0};
    bit m_run[3] = '{1'b0, 1'b0, 1'b0};
    bit m_done[3] = '{1'b0, 1'b0, 1'b0};
    bit m_err[3] = '{1'b0, 1'b0, 1'b0};

    logic [32:0] q[$];
    logic [32:0] mon_e;
    int checks = 0;
    int fails  = 0;

    // Reference: the count is a plain integer 0..99; digits are derived only for comparison.
    task automatic model();
        logic [32:0] e;
        for (int k = 0; k < 3; k++) begin
            if (cr) begin
                m_cnt[k] = 59; m_rl[k] = 59; m_ph[k] = 0;
                m_run[k] = 0; m_done[k] = 0; m_err[k] = 0;
            end else begin
                m_done[k] = 0;
                if (ld) begin
                    if (ldh <= 9 && ldl <= 9) begin
                        m_cnt[k] = ldh * 10 + ldl; m_rl[k] = m_cnt[k];
                        m_ph[k] = 0; m_err[k] = 0; m_run[k] = 0;
                    end else m_err[k] = 1;
                end else if (st && !m_run[k]) begin
                    if (m_cnt[k] == 0) m_done[k] = 1;
                    else begin m_run[k] = 1; m_ph[k] = 0; end
                end else if (m_run[k] && en) begin
                    m_ph[k]++;
                    if (m_ph[k] == DIVS[k]) begin
                        m_ph[k] = 0;
                        m_cnt[k]--;
                        if (m_cnt[k] == 0) begin
                            m_done[k] = 1;
                            if (ARS[k] && m_rl[k] != 0) m_cnt[k] = m_rl[k];
                            else m_run[k] = 0;
                        end
                    end
                end
            end
            e[(2-k)*11 +: 11] = {4'(m_cnt[k] / 10), 4'(m_cnt[k] % 10), m_run[k], m_done[k], m_err[k]};
        end
        q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            model();
            @(posedge CP);
            @(negedge CP);
        end
    endtask

    task automatic drive(input bit c, input bit l, input logic [3:0] h, input logic [3:0] lo,
                         input bit s, input bit e);
        cr = c; ld = l; ldh = h; ldl = lo; st = s; en = e;
    endtask

    task automatic load_start(input logic [3:0] h, input logic [3:0] lo, input int run);
        drive(0, 1, h, lo, 0, 1); cyc(1);
        drive(0, 0, 0, 0, 1, 1); cyc(1);
        drive(0, 0, 0, 0, 0, 1); cyc(run);
    endtask

    initial begin
        forever begin
            @(negedge CP);
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (obs[(2-k)*11 +: 11] !== mon_e[(2-k)*11 +: 11]) begin
                        fails++;
                        $display("FAIL dut%0d t=%0t got cnt=%h%h busy=%b done=%b err=%b exp cnt=%h%h busy=%b done=%b err=%b",
                                 k, $time,
                                 obs[(2-k)*11+7 -: 4], obs[(2-k)*11+3 -: 4], obs[(2-k)*11+2],
                                 obs[(2-k)*11+1], obs[(2-k)*11],
                                 mon_e[(2-k)*11+7 -: 4], mon_e[(2-k)*11+3 -: 4], mon_e[(2-k)*11+2],
                                 mon_e[(2-k)*11+1], mon_e[(2-k)*11]);
                    end
                end
            end
        end
    end

    initial begin
        drive(1, 0, 0, 0, 0, 0); cyc(1);
        drive(0, 0, 0, 0, 0, 0); cyc(20);
        load_start(4'd1, 4'd2, 60);
        load_start(4'd2, 4'd0, 6);
        load_start(4'd1, 4'd0, 6);
        load_start(4'd9, 4'd9, 6);
        load_start(4'd0, 4'd8, 3);
        drive(0, 0, 0, 0, 0, 0); cyc(5);
        drive(0, 0, 0, 0, 0, 1); cyc(12);
        drive(0, 1, 4'd3, 4'd10, 0, 1); cyc(1);
        drive(0, 1, 4'd2, 4'd5, 0, 1); cyc(1);
        drive(0, 0, 0, 0, 1, 1); cyc(3);
        drive(0, 1, 4'd4, 4'd2, 1, 1); cyc(1);
        drive(0, 0, 0, 0, 0, 1); cyc(3);
        load_start(4'd0, 4'd2, 14);
        drive(1, 0, 0, 0, 0, 1); cyc(1);
        drive(0, 0, 0, 0, 0, 1); cyc(3);
        load_start(4'd0, 4'd0, 3);
        repeat (3000) begin
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 7) == 0 ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 2)),
                  $urandom_range(0, 7) == 0 ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9)),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
            cyc(1);
        end
        drive(0, 0, 0, 0, 0, 0);
        @(negedge CP);
        @(negedge CP);
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain left=%0d expected=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
